// File: rtl/ysyx_24100029_arb_pkg.sv
// Shared types for the IFU/LSU memory arbiter: grant encoding and AXI4 channel payloads.
// Anything that decodes the arbiter's grant output should use grant_e from here.
package ysyx_24100029_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } grant_e;

    // AR and AW carry the same request fields.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
    } ax_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [ID_W-1:0]   id;
    } r_t;

    typedef struct packed {
        logic [1:0]      resp;
        logic [ID_W-1:0] id;
    } b_t;

endpackage

// File: rtl/ysyx_24100029_axi_chan_mux.sv
// One AXI request channel (valid/payload forward, ready back) muxed from two masters onto
// the shared port. The unselected master sees ready = 0; with nothing selected the port is all zero.
module ysyx_24100029_axi_chan_mux #(
    parameter int W = 1
) (
    input  logic [1:0]   i_sel,        // [0] master 0 (IFU), [1] master 1 (LSU); at most one set
    input  logic         i_m0_valid,
    input  logic [W-1:0] i_m0_data,
    output logic         o_m0_ready,
    input  logic         i_m1_valid,
    input  logic [W-1:0] i_m1_data,
    output logic         o_m1_ready,
    output logic         o_s_valid,
    output logic [W-1:0] o_s_data,
    input  logic         i_s_ready
);

    // NOTE: every output gets a default before the branches, so no latch can be inferred.
    always_comb begin
        o_s_valid  = 1'b0;
        o_s_data   = '0;
        o_m0_ready = 1'b0;
        o_m1_ready = 1'b0;
        if (i_sel[0]) begin
            o_s_valid  = i_m0_valid;
            o_s_data   = i_m0_data;
            o_m0_ready = i_s_ready;
        end else if (i_sel[1]) begin
            o_s_valid  = i_m1_valid;
            o_s_data   = i_m1_data;
            o_m1_ready = i_s_ready;
        end
    end

endmodule

// File: rtl/ysyx_24100029_mem_arbiter.sv
// Shares the single external AXI4 port between icache refill (IFU, read only) and the LSU.
// Whole transactions are serialised; LSU has priority, bounded by a streak guard for pending fetches.
module ysyx_24100029_mem_arbiter
    import ysyx_24100029_arb_pkg::*;
#(
    parameter int MAX_LSU_STREAK = 4
) (
    input  logic       clock,
    input  logic       reset,
    // IFU master (AW/W/B never granted)
    input  logic       i_ifu_arvalid,
    input  ax_t        i_ifu_ar,
    output logic       o_ifu_arready,
    output logic       o_ifu_rvalid,
    output r_t         o_ifu_r,
    input  logic       i_ifu_rready,
    input  logic       i_ifu_awvalid,
    output logic       o_ifu_awready,
    input  logic       i_ifu_wvalid,
    output logic       o_ifu_wready,
    output logic       o_ifu_bvalid,
    // LSU master
    input  logic       i_lsu_arvalid,
    input  ax_t        i_lsu_ar,
    output logic       o_lsu_arready,
    output logic       o_lsu_rvalid,
    output r_t         o_lsu_r,
    input  logic       i_lsu_rready,
    input  logic       i_lsu_awvalid,
    input  ax_t        i_lsu_aw,
    output logic       o_lsu_awready,
    input  logic       i_lsu_wvalid,
    input  w_t         i_lsu_w,
    output logic       o_lsu_wready,
    output logic       o_lsu_bvalid,
    output b_t         o_lsu_b,
    input  logic       i_lsu_bready,
    // shared downstream port
    output logic       o_mem_arvalid,
    output ax_t        o_mem_ar,
    input  logic       i_mem_arready,
    input  logic       i_mem_rvalid,
    input  r_t         i_mem_r,
    output logic       o_mem_rready,
    output logic       o_mem_awvalid,
    output ax_t        o_mem_aw,
    input  logic       i_mem_awready,
    output logic       o_mem_wvalid,
    output w_t         o_mem_w,
    input  logic       i_mem_wready,
    input  logic       i_mem_bvalid,
    input  b_t         i_mem_b,
    output logic       o_mem_bready,
    output logic [1:0] o_grant
);

    localparam int                  STREAK_W   = $clog2(MAX_LSU_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LSU_STREAK);

    grant_e              r_state;
    grant_e              w_state_d;
    logic [STREAK_W-1:0] r_streak;
    logic [STREAK_W-1:0] w_streak_d;

    logic w_ifu_rd;
    logic w_lsu_rd;
    logic w_lsu_wr;

    assign w_ifu_rd = (r_state == IFU_RD);
    assign w_lsu_rd = (r_state == LSU_RD);
    assign w_lsu_wr = (r_state == LSU_WR);

    always_comb begin
        w_state_d  = r_state;
        w_streak_d = r_streak;
        case (r_state)
            IDLE: begin
                if (i_ifu_arvalid && (r_streak == STREAK_MAX)) w_state_d = IFU_RD;
                else if (i_lsu_awvalid)                         w_state_d = LSU_WR;
                else if (i_lsu_arvalid)                         w_state_d = LSU_RD;
                else if (i_ifu_arvalid)                         w_state_d = IFU_RD;

                // Streak counts LSU grants that overtook a waiting fetch.
                if (w_state_d == IFU_RD) begin
                    w_streak_d = '0;
                end else if (w_state_d != IDLE) begin
                    if (!i_ifu_arvalid)               w_streak_d = '0;
                    else if (r_streak != STREAK_MAX)  w_streak_d = r_streak + 1'b1;
                end
            end
            IFU_RD: if (i_mem_rvalid && i_ifu_rready && i_mem_r.last) w_state_d = IDLE;
            LSU_RD: if (i_mem_rvalid && i_lsu_rready && i_mem_r.last) w_state_d = IDLE;
            LSU_WR: if (i_mem_bvalid && i_lsu_bready)                 w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_streak <= '0;
        end else begin
            r_state  <= w_state_d;
            r_streak <= w_streak_d;
        end
    end

    assign o_grant = r_state;

    ysyx_24100029_axi_chan_mux #(.W($bits(ax_t))) u_ar_mux (
        .i_sel      ({w_lsu_rd, w_ifu_rd}),
        .i_m0_valid (i_ifu_arvalid),
        .i_m0_data  (i_ifu_ar),
        .o_m0_ready (o_ifu_arready),
        .i_m1_valid (i_lsu_arvalid),
        .i_m1_data  (i_lsu_ar),
        .o_m1_ready (o_lsu_arready),
        .o_s_valid  (o_mem_arvalid),
        .o_s_data   (o_mem_ar),
        .i_s_ready  (i_mem_arready)
    );

    // IFU write-side requests are wired in but never selected, so they can never reach memory.
    ysyx_24100029_axi_chan_mux #(.W($bits(ax_t))) u_aw_mux (
        .i_sel      ({w_lsu_wr, 1'b0}),
        .i_m0_valid (i_ifu_awvalid),
        .i_m0_data  ('0),
        .o_m0_ready (o_ifu_awready),
        .i_m1_valid (i_lsu_awvalid),
        .i_m1_data  (i_lsu_aw),
        .o_m1_ready (o_lsu_awready),
        .o_s_valid  (o_mem_awvalid),
        .o_s_data   (o_mem_aw),
        .i_s_ready  (i_mem_awready)
    );

    ysyx_24100029_axi_chan_mux #(.W($bits(w_t))) u_w_mux (
        .i_sel      ({w_lsu_wr, 1'b0}),
        .i_m0_valid (i_ifu_wvalid),
        .i_m0_data  ('0),
        .o_m0_ready (o_ifu_wready),
        .i_m1_valid (i_lsu_wvalid),
        .i_m1_data  (i_lsu_w),
        .o_m1_ready (o_lsu_wready),
        .o_s_valid  (o_mem_wvalid),
        .o_s_data   (o_mem_w),
        .i_s_ready  (i_mem_wready)
    );

    // Response channels: route to the owner only, zero for everyone else.
    assign o_ifu_rvalid = w_ifu_rd & i_mem_rvalid;
    assign o_ifu_r      = w_ifu_rd ? i_mem_r : '0;
    assign o_lsu_rvalid = w_lsu_rd & i_mem_rvalid;
    assign o_lsu_r      = w_lsu_rd ? i_mem_r : '0;
    assign o_mem_rready = (w_ifu_rd & i_ifu_rready) | (w_lsu_rd & i_lsu_rready);

    assign o_lsu_bvalid = w_lsu_wr & i_mem_bvalid;
    assign o_lsu_b      = w_lsu_wr ? i_mem_b : '0;
    assign o_mem_bready = w_lsu_wr & i_lsu_bready;
    assign o_ifu_bvalid = 1'b0;

endmodule

// File: tb/tb_ysyx_24100029_mem_arbiter.sv
// Directed bench for ysyx_24100029_mem_arbiter: an arbitration vector table from IDLE plus
// hand-written burst, write, streak and reset sequences.
module tb_ysyx_24100029_mem_arbiter;
    import ysyx_24100029_arb_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;

    logic i_ifu_arvalid, o_ifu_arready, o_ifu_rvalid, i_ifu_rready;
    logic i_ifu_awvalid, o_ifu_awready, i_ifu_wvalid, o_ifu_wready, o_ifu_bvalid;
    ax_t  i_ifu_ar;
    r_t   o_ifu_r;
    logic i_lsu_arvalid, o_lsu_arready, o_lsu_rvalid, i_lsu_rready;
    logic i_lsu_awvalid, o_lsu_awready, i_lsu_wvalid, o_lsu_wready, o_lsu_bvalid, i_lsu_bready;
    ax_t  i_lsu_ar, i_lsu_aw;
    w_t   i_lsu_w;
    r_t   o_lsu_r;
    b_t   o_lsu_b;
    logic o_mem_arvalid, i_mem_arready, i_mem_rvalid, o_mem_rready;
    logic o_mem_awvalid, i_mem_awready, o_mem_wvalid, i_mem_wready, i_mem_bvalid, o_mem_bready;
    ax_t  o_mem_ar, o_mem_aw;
    w_t   o_mem_w;
    r_t   i_mem_r;
    b_t   i_mem_b;
    logic [1:0] o_grant;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IFU_ADDR = 32'h3000_0000;
    localparam logic [31:0] LSU_RADDR = 32'h8000_0010;
    localparam logic [31:0] LSU_WADDR = 32'h8000_0100;

    ysyx_24100029_mem_arbiter #(.MAX_LSU_STREAK(4)) dut (
        .clock(clock), .reset(reset),
        .i_ifu_arvalid(i_ifu_arvalid), .i_ifu_ar(i_ifu_ar), .o_ifu_arready(o_ifu_arready),
        .o_ifu_rvalid(o_ifu_rvalid), .o_ifu_r(o_ifu_r), .i_ifu_rready(i_ifu_rready),
        .i_ifu_awvalid(i_ifu_awvalid), .o_ifu_awready(o_ifu_awready),
        .i_ifu_wvalid(i_ifu_wvalid), .o_ifu_wready(o_ifu_wready), .o_ifu_bvalid(o_ifu_bvalid),
        .i_lsu_arvalid(i_lsu_arvalid), .i_lsu_ar(i_lsu_ar), .o_lsu_arready(o_lsu_arready),
        .o_lsu_rvalid(o_lsu_rvalid), .o_lsu_r(o_lsu_r), .i_lsu_rready(i_lsu_rready),
        .i_lsu_awvalid(i_lsu_awvalid), .i_lsu_aw(i_lsu_aw), .o_lsu_awready(o_lsu_awready),
        .i_lsu_wvalid(i_lsu_wvalid), .i_lsu_w(i_lsu_w), .o_lsu_wready(o_lsu_wready),
        .o_lsu_bvalid(o_lsu_bvalid), .o_lsu_b(o_lsu_b), .i_lsu_bready(i_lsu_bready),
        .o_mem_arvalid(o_mem_arvalid), .o_mem_ar(o_mem_ar), .i_mem_arready(i_mem_arready),
        .i_mem_rvalid(i_mem_rvalid), .i_mem_r(i_mem_r), .o_mem_rready(o_mem_rready),
        .o_mem_awvalid(o_mem_awvalid), .o_mem_aw(o_mem_aw), .i_mem_awready(i_mem_awready),
        .o_mem_wvalid(o_mem_wvalid), .o_mem_w(o_mem_w), .i_mem_wready(i_mem_wready),
        .i_mem_bvalid(i_mem_bvalid), .i_mem_b(i_mem_b), .o_mem_bready(o_mem_bready),
        .o_grant(o_grant)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        ifu;
        logic        aw;
        logic        ar;
        logic [1:0]  grant;
        logic        mem_arvalid;
        logic        mem_awvalid;
        logic [31:0] araddr;
        logic [31:0] awaddr;
        logic        ifu_arready;
        logic        lsu_arready;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        i_ifu_arvalid = 0; i_ifu_rready = 1; i_ifu_awvalid = 0; i_ifu_wvalid = 0;
        i_ifu_ar = '{addr: IFU_ADDR, id: 4'h1, len: 8'd0, size: 3'd2, burst: 2'b01};
        i_lsu_arvalid = 0; i_lsu_rready = 1; i_lsu_awvalid = 0; i_lsu_wvalid = 0; i_lsu_bready = 1;
        i_lsu_ar = '{addr: LSU_RADDR, id: 4'h2, len: 8'd0, size: 3'd2, burst: 2'b01};
        i_lsu_aw = '{addr: LSU_WADDR, id: 4'h3, len: 8'd0, size: 3'd2, burst: 2'b01};
        i_lsu_w  = '{data: 32'hDEAD_BEEF, strb: 4'b0011, last: 1'b1};
        i_mem_arready = 0; i_mem_rvalid = 0; i_mem_awready = 0; i_mem_wready = 0; i_mem_bvalid = 0;
        i_mem_r = '0;
        i_mem_b = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    // Entered with the FSM already owning the port: one AR handshake, one last beat, back to IDLE.
    task automatic serve_read(input logic [1:0] exp_g, input logic [31:0] data, input string tag);
        logic is_ifu;
        is_ifu = (exp_g == 2'd1);
        check({tag, "_grant"}, o_grant, exp_g);
        check({tag, "_araddr"}, o_mem_ar.addr, is_ifu ? IFU_ADDR : LSU_RADDR);
        i_mem_arready = 1;
        settle();
        check({tag, "_arready"}, {o_ifu_arready, o_lsu_arready}, is_ifu ? 2'b10 : 2'b01);
        tick();
        i_mem_arready = 0;
        if (is_ifu) i_ifu_arvalid = 0; else i_lsu_arvalid = 0;
        i_mem_rvalid = 1;
        i_mem_r = '{data: data, resp: 2'b00, last: 1'b1, id: 4'h0};
        settle();
        check({tag, "_rvalid"}, {o_ifu_rvalid, o_lsu_rvalid}, is_ifu ? 2'b10 : 2'b01);
        check({tag, "_rdata"}, is_ifu ? o_ifu_r.data : o_lsu_r.data, data);
        check({tag, "_rready"}, o_mem_rready, 1'b1);
        tick();
        i_mem_rvalid = 0;
        i_mem_r = '0;
        settle();
        check({tag, "_idle"}, o_grant, 2'd0);
    endtask

    initial begin
        logic [1:0] order[7];
        int lsu_left;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, IFU_ADDR,  32'h0,     1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, LSU_RADDR, 32'h0,     1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 32'h0,     LSU_WADDR, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 32'h0,     LSU_WADDR, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, LSU_RADDR, 32'h0,     1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 32'h0,     LSU_WADDR, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 32'h0,     LSU_WADDR, 1'b0, 1'b0};

        // Reset state
        apply_reset();
        check("rst_grant", o_grant, 2'd0);
        check("rst_streak", dut.r_streak, 3'd0);
        check("rst_mem_valids", {o_mem_arvalid, o_mem_awvalid, o_mem_wvalid}, 3'b000);
        check("rst_mem_readies", {o_mem_rready, o_mem_bready}, 2'b00);
        check("rst_mem_fields", {o_mem_ar.addr, o_mem_aw.addr}, 64'h0);
        check("rst_mem_wdata", o_mem_w.data, 32'h0);

        // Arbitration table: requests seen in IDLE, owner presented one cycle later
        for (int i = 0; i < 8; i++) begin
            apply_reset();
            i_ifu_arvalid = vecs[i].ifu;
            i_lsu_awvalid = vecs[i].aw;
            i_lsu_wvalid  = vecs[i].aw;
            i_lsu_arvalid = vecs[i].ar;
            settle();
            check($sformatf("v%0d_grant_before_edge", i), o_grant, 2'd0);
            tick();
            check($sformatf("v%0d_grant", i), o_grant, vecs[i].grant);
            check($sformatf("v%0d_mem_arvalid", i), o_mem_arvalid, vecs[i].mem_arvalid);
            check($sformatf("v%0d_mem_awvalid", i), o_mem_awvalid, vecs[i].mem_awvalid);
            check($sformatf("v%0d_mem_wvalid", i), o_mem_wvalid, vecs[i].mem_awvalid);
            check($sformatf("v%0d_araddr", i), o_mem_ar.addr, vecs[i].araddr);
            check($sformatf("v%0d_awaddr", i), o_mem_aw.addr, vecs[i].awaddr);
            i_mem_arready = 1;
            settle();
            check($sformatf("v%0d_ifu_arready", i), o_ifu_arready, vecs[i].ifu_arready);
            check($sformatf("v%0d_lsu_arready", i), o_lsu_arready, vecs[i].lsu_arready);
        end

        // IFU 4-beat burst
        apply_reset();
        i_ifu_arvalid = 1;
        i_ifu_ar.len = 8'd3;
        tick();
        check("burst_grant", o_grant, 2'd1);
        check("burst_arlen", o_mem_ar.len, 8'd3);
        i_mem_arready = 1;
        settle();
        check("burst_arready", o_ifu_arready, 1'b1);
        tick();
        i_mem_arready = 0;
        i_ifu_arvalid = 0;
        for (int k = 0; k < 4; k++) begin
            i_mem_rvalid = 1;
            i_mem_r = '{data: 32'hA000_0000 + k, resp: 2'b00, last: (k == 3), id: 4'h1};
            settle();
            check($sformatf("burst_b%0d_grant", k), o_grant, 2'd1);
            check($sformatf("burst_b%0d_rvalid", k), {o_ifu_rvalid, o_lsu_rvalid}, 2'b10);
            check($sformatf("burst_b%0d_data", k), o_ifu_r.data, 32'hA000_0000 + k);
            check($sformatf("burst_b%0d_last", k), o_ifu_r.last, k == 3);
            tick();
        end
        i_mem_rvalid = 0;
        settle();
        check("burst_done_grant", o_grant, 2'd0);
        check("burst_done_rready", o_mem_rready, 1'b0);

        // Simultaneous IFU + LSU read: LSU first, one idle cycle, then IFU
        apply_reset();
        i_ifu_arvalid = 1;
        i_lsu_arvalid = 1;
        tick();
        serve_read(2'd2, 32'h1111_2222, "sim_lsu");
        tick();
        serve_read(2'd1, 32'h3333_4444, "sim_ifu");

        // LSU write: W before AW, AW delayed 3 cycles; IFU write requests never forwarded
        apply_reset();
        i_ifu_awvalid = 1;
        i_ifu_wvalid = 1;
        i_mem_awready = 1;
        i_mem_wready = 1;
        tick();
        check("ifuw_grant", o_grant, 2'd0);
        check("ifuw_mem_awvalid", {o_mem_awvalid, o_mem_wvalid}, 2'b00);
        check("ifuw_ready", {o_ifu_awready, o_ifu_wready}, 2'b00);
        i_mem_awready = 0;
        i_lsu_awvalid = 1;
        i_lsu_wvalid = 1;
        tick();
        check("wr_grant_c1", o_grant, 2'd3);
        check("wr_mem_valids", {o_mem_awvalid, o_mem_wvalid}, 2'b11);
        check("wr_wdata", o_mem_w.data, 32'hDEAD_BEEF);
        check("wr_wstrb", o_mem_w.strb, 4'b0011);
        check("wr_lsu_readies", {o_lsu_awready, o_lsu_wready}, 2'b01);
        check("wr_ifu_wready", o_ifu_wready, 1'b0);
        tick();
        i_lsu_wvalid = 0;
        i_mem_wready = 0;
        settle();
        check("wr_grant_c2", o_grant, 2'd3);
        check("wr_mem_wvalid_c2", o_mem_wvalid, 1'b0);
        tick();
        check("wr_grant_c3", o_grant, 2'd3);
        check("wr_awvalid_c3", o_mem_awvalid, 1'b1);
        tick();
        i_mem_awready = 1;
        settle();
        check("wr_awaddr", o_mem_aw.addr, LSU_WADDR);
        check("wr_aw_readies", {o_ifu_awready, o_lsu_awready}, 2'b01);
        tick();
        i_lsu_awvalid = 0;
        i_mem_awready = 0;
        settle();
        check("wr_wait_b_grant", o_grant, 2'd3);
        check("wr_wait_b_bvalid", o_lsu_bvalid, 1'b0);
        i_mem_bvalid = 1;
        i_mem_b = '{resp: 2'b00, id: 4'h3};
        settle();
        check("wr_bvalid", {o_ifu_bvalid, o_lsu_bvalid}, 2'b01);
        check("wr_bresp", {o_lsu_b.resp, o_lsu_b.id}, 6'h03);
        check("wr_bready", o_mem_bready, 1'b1);
        tick();
        i_mem_bvalid = 0;
        settle();
        check("wr_done_grant", o_grant, 2'd0);
        check("wr_done_awvalid", o_mem_awvalid, 1'b0);

        // Streak guard: IFU waiting, LSU issues 6 reads -> LSU x4, IFU, LSU x2
        apply_reset();
        order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2};
        lsu_left = 6;
        for (int i = 0; i < 7; i++) begin
            i_ifu_arvalid = 1;
            i_lsu_arvalid = (lsu_left > 0);
            settle();
            if (i == 4) check("streak_at_limit", dut.r_streak, 3'd4);
            tick();
            if (i == 4) check("streak_after_ifu", dut.r_streak, 3'd0);
            serve_read(order[i], 32'h5000_0000 + i, $sformatf("streak_t%0d", i));
            if (order[i] == 2'd2) lsu_left--;
        end
        check("streak_final", dut.r_streak, 3'd2);

        // Reset mid-burst after beat 2 of 4, then a clean LSU read
        apply_reset();
        i_ifu_arvalid = 1;
        i_ifu_ar.len = 8'd3;
        tick();
        i_mem_arready = 1;
        tick();
        i_mem_arready = 0;
        i_ifu_arvalid = 0;
        for (int k = 0; k < 2; k++) begin
            i_mem_rvalid = 1;
            i_mem_r = '{data: 32'hB000_0000 + k, resp: 2'b00, last: 1'b0, id: 4'h1};
            tick();
        end
        settle();
        check("mid_pre_rready", o_mem_rready, 1'b1);
        reset = 1'b1;
        settle();
        check("mid_rst_grant", o_grant, 2'd0);
        check("mid_rst_rready", o_mem_rready, 1'b0);
        check("mid_rst_rvalid", o_ifu_rvalid, 1'b0);
        clear_inputs();
        tick();
        reset = 1'b0;
        settle();
        i_lsu_arvalid = 1;
        tick();
        serve_read(2'd2, 32'h1234_5678, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
